data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port, word-wide, synchronous-read data memory.
- Port 0 is the core load/store path; port 1 is the debug/program-loader path.
- Sub-word stores (byte enables not all set) are turned into a read-modify-write, because the memory has only one whole-word write enable.
- Memory contract: address and write inputs are sampled on the rising edge; read data is valid the next cycle; a write cycle returns the written word on the read-data bus.

Parameters:
- DATA_WIDTH, 32, memory word width; must be 32 (four byte lanes).
- ADDR_WIDTH, 10, word-address width of the memory.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_we  in  1  1 = store, 0 = load
- p0_req_addr  in  ADDR_WIDTH  word address
- p0_req_wdata  in  DATA_WIDTH  store data, lane-aligned
- p0_req_be  in  4  byte enables, bit i = bits [8i+7:8i]
- p0_resp_valid  out  1  one-cycle completion pulse
- p0_resp_rdata  out  DATA_WIDTH  load data, valid with p0_resp_valid on loads
- p1_*  same set as p0_*, for port 1
- mem_a  out  ADDR_WIDTH  to memory address input
- mem_we  out  1  to memory write enable
- mem_wd  out  DATA_WIDTH  to memory write data
- mem_rd  in  DATA_WIDTH  from memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state = IDLE; last_grant = 1, so port 0 wins first.
- FSM states: IDLE, ISSUE, RD_WAIT, RMW_WR, DONE.
- IDLE, arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: the port other than last_grant is granted.
  - The granted port's req_ready is driven high combinationally in IDLE only. req_ready is 0 in every other state.
  - On accept, latch port id, we, addr, wdata and be; update last_grant; go to ISSUE.
- ISSUE:
  - mem_a = latched addr in this state and every later state.
  - Load: mem_we = 0; go to RD_WAIT.
  - Store with be = 4'hF: mem_we = 1, mem_wd = wdata; go to DONE.
  - Store with be = 4'h0: mem_we = 0; go to DONE. This is a no-op store that is still acknowledged.
  - Store with partial be: mem_we = 0 (read phase); go to RD_WAIT.
- RD_WAIT:
  - Load: resp_valid = 1 for the owning port; resp_rdata = mem_rd; return to IDLE.
  - Partial store: register merged = (mem_rd AND NOT mask) OR (wdata AND mask), where mask expands be per byte lane; go to RMW_WR.
- RMW_WR: mem_we = 1, mem_wd = merged; go to DONE.
- DONE: resp_valid = 1 for the owning port; return to IDLE.
- Responses:
  - resp_valid pulses only on the port owning the transaction.
  - Owner's resp_rdata is held until its next response; the other port's is unchanged.
  - Store responses leave resp_rdata unchanged.
- Latency, with accept at cycle T:
  - Load: resp_valid at T+2.
  - Full or no-op store: resp_valid at T+2.
  - Partial store: resp_valid at T+4.
- Throughput: a new request can be accepted in the cycle after resp_valid. The block never accepts a request while busy.
- A request that is not granted stays pending. Requesters must hold valid and payload stable until ready.
- mem_we is 1 only in ISSUE (full store) and RMW_WR. It is never asserted in IDLE.
- Reset mid-transaction:
  - State returns to IDLE immediately; mem_we drops asynchronously.
  - The in-flight transaction is dropped with no resp_valid.
  - A partial store interrupted before RMW_WR leaves memory unchanged.

Test Plan:
- Reset, then port 0 store addr 5, wdata 32'hDEADBEEF, be F at T -> mem_we = 1 at T+1, p0_resp_valid at T+2. Then port 0 load addr 5 -> p0_resp_rdata = 32'hDEADBEEF two cycles after accept.
- Memory word 5 = 32'hDEADBEEF; port 1 store addr 5, wdata 32'h00AA0000, be 4'b0100 -> read in ISSUE, write in RMW_WR with mem_wd = 32'hDEAABEEF, p1_resp_valid at T+4. Reload returns 32'hDEAABEEF.
- Both ports hold loads valid continuously from reset -> grants alternate 0,1,0,1. Each resp_valid pulses only on its owner; p0_req_ready never coincides with p1_req_ready.
- Store with be 0 to addr 7 holding 32'h12345678 -> mem_we never asserted, resp_valid at T+2, word 7 still 32'h12345678.
- Assert rst during RD_WAIT of a partial store -> busy = 0 and mem_we = 0 immediately, no resp_valid, target word unchanged. Arbitration restarts with port 0 priority.
- Port 1 request arrives while port 0 load is in ISSUE -> p1_req_ready stays 0 until IDLE, then port 1 is accepted in the cycle after p0_resp_valid.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port synchronous-read data memory.
// Sub-word stores become a read-modify-write because the memory only has a whole-word write enable.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  input  logic [3:0]            p0_req_be,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  input  logic [3:0]            p1_req_be,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, RMW_WR, DONE} state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg;
  logic                  owner_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            be_reg;
  logic [DATA_WIDTH-1:0] merged_reg;
  logic [DATA_WIDTH-1:0] p0_rdata_reg, p1_rdata_reg;

  logic                  grant_valid;
  logic                  grant_port;
  logic                  accept;
  logic                  resp_fire;
  logic                  load_resp;
  logic [DATA_WIDTH-1:0] be_mask;

  // Both requesting: the port that did not win last time gets the grant.
  always_comb begin
    grant_valid = p0_req_valid | p1_req_valid;
    if (p0_req_valid && p1_req_valid) begin
      grant_port = ~last_grant_reg;
    end else begin
      grant_port = p1_req_valid;
    end
  end

  assign accept       = (state_reg == IDLE) && grant_valid;
  assign p0_req_ready = accept && !grant_port;
  assign p1_req_ready = accept && grant_port;
  assign busy         = (state_reg != IDLE);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
    assign be_mask[8*gi +: 8] = {8{be_reg[gi]}};
  end

  always_comb begin
    state_next = state_reg;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    resp_fire  = 1'b0;
    load_resp  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_a = addr_reg;
        if (!we_reg) begin
          state_next = RD_WAIT;
        end else if (be_reg == 4'hF) begin
          mem_we     = 1'b1;
          mem_wd     = wdata_reg;
          state_next = DONE;
        end else if (be_reg == 4'h0) begin
          state_next = DONE;
        end else begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_a = addr_reg;
        if (!we_reg) begin
          resp_fire  = 1'b1;
          load_resp  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_a      = addr_reg;
        mem_we     = 1'b1;
        mem_wd     = merged_reg;
        state_next = DONE;
      end
      DONE: begin
        mem_a      = addr_reg;
        resp_fire  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load data is forwarded straight from the memory on the response cycle, then held.
  assign p0_resp_valid = resp_fire && !owner_reg;
  assign p1_resp_valid = resp_fire && owner_reg;
  assign p0_resp_rdata = (load_resp && !owner_reg) ? mem_rd : p0_rdata_reg;
  assign p1_resp_rdata = (load_resp && owner_reg) ? mem_rd : p1_rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      merged_reg     <= '0;
      p0_rdata_reg   <= '0;
      p1_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg      <= grant_port;
        last_grant_reg <= grant_port;
        we_reg         <= grant_port ? p1_req_we    : p0_req_we;
        addr_reg       <= grant_port ? p1_req_addr  : p0_req_addr;
        wdata_reg      <= grant_port ? p1_req_wdata : p0_req_wdata;
        be_reg         <= grant_port ? p1_req_be    : p0_req_be;
      end
      if (state_reg == RD_WAIT && we_reg) begin
        merged_reg <= (mem_rd & ~be_mask) | (wdata_reg & be_mask);
      end
      if (load_resp) begin
        if (owner_reg) begin
          p1_rdata_reg <= mem_rd;
        end else begin
          p0_rdata_reg <= mem_rd;
        end
      end
    end
  end

endmodule
